// File: rtl/irig_time_msg_sender.sv
// ---------------------------------------------------------------------------
// irig_time_msg_sender
//
// Purpose:
//   Sits between the IRIG-B decoder and the UART transmitter. On every
//   accepted decoded-frame strobe it snapshots the BCD time fields and
//   streams the ASCII message "TIME:20YY-DDDday-HH:MM:SS" (optionally
//   followed by CR LF) one byte per paced strobe. Frames that arrive while
//   a message is still in flight are dropped and counted.
//
// Parameters:
//   BYTE_GAP    - clock cycles between successive tx_valid strobes (2..65535)
//   APPEND_CRLF - 1: 27-byte message ending in CR LF, 0: 25-byte message
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   frame_valid in   single-cycle pulse, time fields valid this cycle
//   year_bcd    in   [7:0]  {tens, units}
//   day_bcd     in   [11:0] {hundreds, tens, units}, day-of-year
//   hour_bcd    in   [7:0]  {tens, units}
//   min_bcd     in   [7:0]  {tens, units}
//   sec_bcd     in   [7:0]  {tens, units}
//   tx_data     out  [7:0]  ASCII byte, qualified by tx_valid
//   tx_valid    out  single-cycle byte strobe
//   busy        out  message in progress
//   done        out  single-cycle pulse when a message completes
//   drop_cnt    out  [7:0]  saturating count of dropped frames
// ---------------------------------------------------------------------------
module irig_time_msg_sender #(
  parameter int unsigned BYTE_GAP    = 60000,
  parameter int unsigned APPEND_CRLF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [7:0]  year_bcd,
  input  logic [11:0] day_bcd,
  input  logic [7:0]  hour_bcd,
  input  logic [7:0]  min_bcd,
  input  logic [7:0]  sec_bcd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  drop_cnt
);

  // Index of the final byte of the message.
  localparam logic [4:0]  LAST_IDX = (APPEND_CRLF != 0) ? 5'd26 : 5'd24;
  // The gap counter runs 0..GAP_TC; together with the SEND cycle this
  // spaces strobes exactly BYTE_GAP cycles apart.
  localparam logic [15:0] GAP_TC   = 16'(BYTE_GAP - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // One BCD digit to ASCII; non-decimal nibbles become '?'.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] digit);
    logic [7:0] res;
    if (digit <= 4'd9) begin
      res = 8'h30 + {4'h0, digit};
    end else begin
      res = 8'h3F;
    end
    return res;
  endfunction

  // Message byte at position idx, built from the given time fields.
  function automatic logic [7:0] msg_byte(
    input logic [4:0]  idx,
    input logic [7:0]  yy,
    input logic [11:0] ddd,
    input logic [7:0]  hh,
    input logic [7:0]  mm,
    input logic [7:0]  ss
  );
    logic [7:0] res;
    case (idx)
      5'd0:    res = 8'h54;              // 'T'
      5'd1:    res = 8'h49;              // 'I'
      5'd2:    res = 8'h4D;              // 'M'
      5'd3:    res = 8'h45;              // 'E'
      5'd4:    res = 8'h3A;              // ':'
      5'd5:    res = 8'h32;              // '2'
      5'd6:    res = 8'h30;              // '0'
      5'd7:    res = bcd_ascii(yy[7:4]);
      5'd8:    res = bcd_ascii(yy[3:0]);
      5'd9:    res = 8'h2D;              // '-'
      5'd10:   res = bcd_ascii(ddd[11:8]);
      5'd11:   res = bcd_ascii(ddd[7:4]);
      5'd12:   res = bcd_ascii(ddd[3:0]);
      5'd13:   res = 8'h64;              // 'd'
      5'd14:   res = 8'h61;              // 'a'
      5'd15:   res = 8'h79;              // 'y'
      5'd16:   res = 8'h2D;              // '-'
      5'd17:   res = bcd_ascii(hh[7:4]);
      5'd18:   res = bcd_ascii(hh[3:0]);
      5'd19:   res = 8'h3A;              // ':'
      5'd20:   res = bcd_ascii(mm[7:4]);
      5'd21:   res = bcd_ascii(mm[3:0]);
      5'd22:   res = 8'h3A;              // ':'
      5'd23:   res = bcd_ascii(ss[7:4]);
      5'd24:   res = bcd_ascii(ss[3:0]);
      5'd25:   res = 8'h0D;              // CR
      5'd26:   res = 8'h0A;              // LF
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q;
  logic [4:0]  idx_q;
  logic [15:0] gap_q;
  logic [7:0]  year_q;
  logic [11:0] day_q;
  logic [7:0]  hour_q;
  logic [7:0]  min_q;
  logic [7:0]  sec_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  drop_q;

  logic        accept_d;
  logic        overrun_d;
  logic        gap_tc_d;
  logic        last_d;
  logic [4:0]  idx_d;
  logic [7:0]  byte_d;

  // Frame acceptance, overrun detection and the byte for the next strobe.
  always_comb begin
    // The done cycle still counts as occupied, so a frame there is dropped.
    accept_d  = (state_q == IDLE) && frame_valid && !done_q;
    overrun_d = frame_valid && (busy_q || done_q);
    gap_tc_d  = (gap_q == GAP_TC);
    last_d    = (idx_q == LAST_IDX);
    // The first byte is produced in the same edge that takes the snapshot,
    // so it is built from the live inputs; later bytes use the snapshot.
    if (accept_d) begin
      idx_d  = 5'd0;
      byte_d = msg_byte(5'd0, year_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd);
    end else begin
      idx_d  = idx_q + 5'd1;
      byte_d = msg_byte(idx_d, year_q, day_q, hour_q, min_q, sec_q);
    end
  end

  // Sequencer FSM with registered outputs and the drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 5'd0;
      gap_q      <= 16'd0;
      year_q     <= 8'h00;
      day_q      <= 12'h000;
      hour_q     <= 8'h00;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 8'h00;
    end else begin
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;

      if (overrun_d && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end

      case (state_q)
        IDLE: begin
          if (accept_d) begin
            year_q     <= year_bcd;
            day_q      <= day_bcd;
            hour_q     <= hour_bcd;
            min_q      <= min_bcd;
            sec_q      <= sec_bcd;
            idx_q      <= idx_d;
            tx_data_q  <= byte_d;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end

        // tx_valid is high during this single cycle.
        SEND: begin
          gap_q   <= 16'd0;
          state_q <= GAP;
        end

        GAP: begin
          if (gap_tc_d) begin
            if (last_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q      <= idx_d;
              tx_data_q  <= byte_d;
              tx_valid_q <= 1'b1;
              state_q    <= SEND;
            end
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_irig_time_msg_sender.sv
module tb_irig_time_msg_sender;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fa  = 1'b0;
  logic        fb  = 1'b0;
  logic [7:0]  year = 8'h00;
  logic [11:0] day  = 12'h000;
  logic [7:0]  hour = 8'h00;
  logic [7:0]  mins = 8'h00;
  logic [7:0]  sec  = 8'h00;

  logic [7:0]  txd_a, drop_a, txd_b, drop_b;
  logic        txv_a, busy_a, done_a, txv_b, busy_b, done_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int exp_byte_a[$];
  int exp_cyc_a[$];
  int exp_done_a[$];
  int exp_byte_b[$];
  int exp_cyc_b[$];
  int exp_done_b[$];

  irig_time_msg_sender #(.BYTE_GAP(GAP), .APPEND_CRLF(1)) dut_a (
    .clk(clk), .rst(rst), .frame_valid(fa),
    .year_bcd(year), .day_bcd(day), .hour_bcd(hour), .min_bcd(mins), .sec_bcd(sec),
    .tx_data(txd_a), .tx_valid(txv_a), .busy(busy_a), .done(done_a), .drop_cnt(drop_a)
  );

  irig_time_msg_sender #(.BYTE_GAP(GAP), .APPEND_CRLF(0)) dut_b (
    .clk(clk), .rst(rst), .frame_valid(fb),
    .year_bcd(year), .day_bcd(day), .hour_bcd(hour), .min_bcd(mins), .sec_bcd(sec),
    .tx_data(txd_b), .tx_valid(txv_b), .busy(busy_b), .done(done_b), .drop_cnt(drop_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic set_fields(input logic [7:0] y, input logic [11:0] d,
                            input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    year = y; day = d; hour = h; mins = m; sec = s;
  endtask

  // Queue the expected strobes (byte and observation cycle) of a message.
  task automatic push_msg(input bit to_b, input string s, input bit crlf,
                          input int k, input int nbytes, input bit with_done);
    int total;
    int b;
    total = s.len() + (crlf ? 2 : 0);
    for (int i = 0; i < nbytes; i++) begin
      if (i < s.len())       b = int'(s[i]);
      else if (i == s.len()) b = 'h0D;
      else                   b = 'h0A;
      if (to_b) begin exp_byte_b.push_back(b); exp_cyc_b.push_back(k + GAP * i); end
      else      begin exp_byte_a.push_back(b); exp_cyc_a.push_back(k + GAP * i); end
    end
    if (with_done) begin
      if (to_b) exp_done_b.push_back(k + GAP * total);
      else      exp_done_a.push_back(k + GAP * total);
    end
  endtask

  // Called at a negedge: pulse frame_valid on DUT A for one cycle.
  task automatic start_a(input string s, input int nbytes, input bit with_done,
                         output int k);
    fa = 1'b1;
    k  = cyc + 1;
    push_msg(1'b0, s, 1'b1, k, nbytes, with_done);
    @(negedge clk);
    fa = 1'b0;
  endtask

  // Returns at the negedge where done is seen (bounded wait).
  task automatic wait_done(input bit on_b, output int dcyc);
    bit found;
    found = 1'b0;
    dcyc  = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if ((on_b ? done_b : done_a) === 1'b1) begin
        found = 1'b1;
        dcyc  = cyc;
      end
    end
    if (!found) chk(on_b ? "done_timeout_b" : "done_timeout_a", 0, 1);
  endtask

  // Scoreboard monitor for DUT A.
  always @(negedge clk) begin
    if (txv_a === 1'b1) begin
      if (exp_byte_a.size() == 0) begin
        chk("unexpected_strobe_a", 1, 0);
      end else begin
        chk("byte_a", txd_a, exp_byte_a.pop_front());
        chk("strobe_cycle_a", cyc, exp_cyc_a.pop_front());
      end
    end
    if (done_a === 1'b1) begin
      if (exp_done_a.size() == 0) chk("unexpected_done_a", 1, 0);
      else                        chk("done_cycle_a", cyc, exp_done_a.pop_front());
    end
  end

  // Scoreboard monitor for DUT B.
  always @(negedge clk) begin
    if (txv_b === 1'b1) begin
      if (exp_byte_b.size() == 0) begin
        chk("unexpected_strobe_b", 1, 0);
      end else begin
        chk("byte_b", txd_b, exp_byte_b.pop_front());
        chk("strobe_cycle_b", cyc, exp_cyc_b.pop_front());
      end
    end
    if (done_b === 1'b1) begin
      if (exp_done_b.size() == 0) chk("unexpected_done_b", 1, 0);
      else                        chk("done_cycle_b", cyc, exp_done_b.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s1;
    string s3;
    int k;
    int d;
    s1 = "TIME:2023-240day-11:50:34";
    s3 = "TIME:2023-240day-11:5?:34";

    // Reset state.
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_data_a", txd_a, 0);
    chk("rst_tx_valid_a", txv_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_drop_a", drop_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Message 1 with an overrun 40 cycles in and changed inputs.
    set_fields(8'h23, 12'h240, 8'h11, 8'h50, 8'h34);
    start_a(s1, 27, 1'b1, k);
    chk("busy_after_start_a", busy_a, 1);
    repeat (39) @(negedge clk);
    set_fields(8'h99, 12'h365, 8'h22, 8'h59, 8'h58);
    fa = 1'b1;
    @(negedge clk);
    fa = 1'b0;
    wait_done(1'b0, d);
    chk("drop_after_overrun", drop_a, 1);
    chk("busy_on_done_a", busy_a, 0);

    // Back-to-back frame on the cycle after done, invalid minute digit.
    @(negedge clk);
    set_fields(8'h23, 12'h240, 8'h11, 8'h5C, 8'h34);
    start_a(s3, 27, 1'b1, k);
    chk("drop_after_b2b", drop_a, 1);

    // Frame on the done cycle itself is dropped.
    wait_done(1'b0, d);
    fa = 1'b1;
    @(negedge clk);
    fa = 1'b0;
    @(negedge clk);
    chk("drop_on_done_cycle", drop_a, 2);
    chk("no_start_on_done_cycle", busy_a, 0);
    repeat (20) @(negedge clk);
    chk("idle_after_drop", busy_a, 0);

    // Saturation: 300 overrun cycles across two messages.
    set_fields(8'h23, 12'h240, 8'h11, 8'h50, 8'h34);
    start_a(s1, 27, 1'b1, k);
    fa = 1'b1;
    repeat (150) @(negedge clk);
    fa = 1'b0;
    chk("drop_count_152", drop_a, 152);
    wait_done(1'b0, d);
    @(negedge clk);
    start_a(s1, 27, 1'b1, k);
    fa = 1'b1;
    repeat (150) @(negedge clk);
    fa = 1'b0;
    chk("drop_saturated", drop_a, 255);
    wait_done(1'b0, d);
    chk("drop_stays_saturated", drop_a, 255);

    // No CR LF variant: 25 bytes.
    repeat (2) @(negedge clk);
    fb = 1'b1;
    push_msg(1'b1, s1, 1'b0, cyc + 1, 25, 1'b1);
    @(negedge clk);
    fb = 1'b0;
    wait_done(1'b1, d);
    chk("drop_b_zero", drop_b, 0);
    chk("queue_b_drained", exp_byte_b.size(), 0);

    // Reset during the gap after byte 12, then restart.
    repeat (3) @(negedge clk);
    start_a(s1, 13, 1'b0, k);
    for (int i = 0; i < 200 && cyc < k + 12 * GAP + 2; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", txv_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_tx_data", txd_a, 0);
    chk("midrst_drop", drop_a, 0);
    chk("midrst_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("aborted_bytes_seen", exp_byte_a.size(), 0);
    chk("idle_after_rst", busy_a, 0);
    start_a(s1, 27, 1'b1, k);
    wait_done(1'b0, d);
    repeat (5) @(negedge clk);
    chk("queue_a_drained", exp_byte_a.size(), 0);
    chk("done_queue_a_drained", exp_done_a.size(), 0);
    chk("done_queue_b_drained", exp_done_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
